cam_capture: RTL and testbench
==============================

Name: cam_capture

Overview:
- Camera pixel-bus front end, clocked by the camera PCLK.
- Frames the raw sensor bus (VSYNC/HREF/D[7:0]) into a one-shot byte stream and feeds the frame-dump buffer write port: frame_start, frame_end, write_en, write_data.
- One frame is captured per arm request.
- Checks line and frame geometry, and reports dropped bytes when the buffer is full.

Parameters:
- H_BYTES, 1280: expected bytes per line (640 px × 2 bytes YUV422).
- V_LINES, 480: expected lines per frame.
- LINE_W, 10: width of line_cnt; must satisfy 2^LINE_W > V_LINES.
- VSYNC_POL, 1: 1 = VSYNC active-high, 0 = active-low.

Ports:
- cam_pclk  in  1  capture clock (camera PCLK).
- cam_reset  in  1  asynchronous reset, active-high.
- cam_vsync  in  1  sensor VSYNC.
- cam_href  in  1  sensor HREF, high while a line's bytes are valid.
- cam_d  in  8  sensor data byte.
- arm  in  1  single-cycle request to capture the next complete frame.
- wr_full  in  1  dump buffer cannot accept a byte this cycle.
- frame_start  out  1  one-cycle pulse at start of the captured frame.
- frame_end  out  1  one-cycle pulse at end of the captured frame.
- write_en  out  1  write strobe to dump buffer.
- write_data  out  8  byte to write.
- busy  out  1  high in WAIT_VS and ACTIVE.
- line_cnt  out  LINE_W  lines accepted in the current or last frame.
- len_err  out  1  sticky geometry error.
- ovf_err  out  1  sticky dropped-byte error.

Behaviour:
- Clock and reset: single clock cam_pclk; reset cam_reset is asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, all counters 0. An asynchronous reset mid-frame aborts immediately; no frame_end is generated.
- Input stage: vsync (polarity-normalised), href and d are registered once (s1), then again for href/vsync (s2).
  - vs_rise = s1 & ~s2; vs_fall = ~s1 & s2; href_fall = ~href_s1 & href_s2.
- Write path latency: a byte sampled at PCLK edge n appears as write_en=1 / write_data after edge n+1 (2 edges pin-to-output). write_en is a one-cycle strobe per byte.
- State IDLE:
  - arm → WAIT_VS; clears len_err, ovf_err, line_cnt and the byte counter.
- State WAIT_VS:
  - Any in-progress frame is ignored.
  - vs_fall → ACTIVE, frame_start=1 for exactly one cycle.
  - arm is ignored.
- State ACTIVE:
  - While href_s1=1, each byte increments byte_cnt (saturating at H_BYTES+1).
  - A byte is written only if byte_cnt < H_BYTES, line_cnt < V_LINES and wr_full=0.
  - If wr_full=1 for a byte that would otherwise be written: byte dropped, ovf_err←1. The counters still advance.
  - href_fall: if byte_cnt ≠ H_BYTES, len_err←1. Then line_cnt increments (saturating at 2^LINE_W−1) and byte_cnt←0.
  - vs_rise: if line_cnt ≠ V_LINES, len_err←1. frame_end=1 for one cycle, → IDLE.
  - An href_fall coinciding with vs_rise is processed first, so it is counted in that frame's line check.
  - arm is ignored.
- Boundary conditions:
  - Extra bytes beyond H_BYTES and extra lines beyond V_LINES are counted but never written.
  - A short line still advances line_cnt.
  - An arm in the same cycle as an ACTIVE→IDLE transition is ignored; it must be reissued.
- Holding: line_cnt, len_err and ovf_err hold their values in IDLE until the next arm.
- busy = (state ≠ IDLE).

Test Plan:
1. H_BYTES=4, V_LINES=3. Arm, VSYNC pulse, then 3 lines of bytes 0x10..0x1B, then VSYNC rise.
   - Required: one frame_start after the VSYNC fall; 12 write_en strobes carrying 0x10..0x1B in order, each 2 edges after its sample.
   - Required: one frame_end at the VSYNC rise; line_cnt=3, len_err=0, ovf_err=0; busy falls to 0.
2. No arm, full frame driven.
   - Required: no write_en, frame_start or frame_end; busy=0.
3. Arm issued mid-frame after VSYNC fell (line 2 of 3 in progress).
   - Required: no writes for the remainder of that frame; capture begins at the next VSYNC fall and yields exactly 12 writes.
4. Line 1 has 3 bytes, line 2 has 5 bytes (0xA0..0xA4).
   - Required: line 1 gives 3 writes; line 2 gives 4 writes, with 0xA4 not written.
   - Required: len_err=1 after line 1's HREF fall; line_cnt=3 at frame_end.
5. wr_full=1 for exactly the cycle in which byte 0x12 would be written.
   - Required: 11 writes with 0x12 missing, ovf_err=1, len_err=0.
6. cam_reset asserted during line 2, then released; then re-arm and drive a full frame.
   - Required: write_en and busy go to 0 asynchronously; no frame_end for the aborted frame.
   - Required: the next armed frame captures normally with 12 writes.

Source files
------------

// File: rtl/cam_capture.sv
// Camera pixel-bus front end: frames VSYNC/HREF/D into a one-shot byte
// stream for the frame-dump buffer and checks line/frame geometry.
module cam_capture #(
  parameter int H_BYTES   = 1280,
  parameter int V_LINES   = 480,
  parameter int LINE_W    = 10,
  parameter int VSYNC_POL = 1
) (
  input  logic              cam_pclk,
  input  logic              cam_reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  input  logic              arm,
  input  logic              wr_full,
  output logic              frame_start,
  output logic              frame_end,
  output logic              write_en,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic [LINE_W-1:0] line_cnt,
  output logic              len_err,
  output logic              ovf_err
);

  localparam int BW = $clog2(H_BYTES + 2);

  localparam logic [BW-1:0] H_MAX  = BW'(H_BYTES);
  localparam logic [BW-1:0] H_SAT  = BW'(H_BYTES + 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  localparam logic [LINE_W-1:0] V_MAX = LINE_W'(V_LINES);
  localparam logic [LINE_W-1:0] L_SAT = '1;
  localparam logic [LINE_W-1:0] L_ONE = LINE_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic vs_s1_q, vs_s1_d;
  logic vs_s2_q, vs_s2_d;
  logic href_s1_q, href_s1_d;
  logic href_s2_q, href_s2_d;
  logic [7:0] d_s1_q, d_s1_d;

  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic len_err_q, len_err_d;
  logic ovf_err_q, ovf_err_d;
  logic frame_start_q, frame_start_d;
  logic frame_end_q, frame_end_d;
  logic write_en_q, write_en_d;
  logic [7:0] write_data_q, write_data_d;

  logic vs_in;
  logic vs_rise;
  logic vs_fall;
  logic href_fall;

  // Normalise VSYNC so that 1 always means "vertical blanking".
  assign vs_in = (VSYNC_POL != 0) ? cam_vsync : ~cam_vsync;

  assign vs_rise   = vs_s1_q & ~vs_s2_q;
  assign vs_fall   = ~vs_s1_q & vs_s2_q;
  assign href_fall = ~href_s1_q & href_s2_q;

  always_comb begin
    vs_s1_d   = vs_in;
    vs_s2_d   = vs_s1_q;
    href_s1_d = cam_href;
    href_s2_d = href_s1_q;
    d_s1_d    = cam_d;
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    line_cnt_d    = line_cnt_q;
    len_err_d     = len_err_q;
    ovf_err_d     = ovf_err_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    write_en_d    = 1'b0;
    write_data_d  = write_data_q;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = WAIT_VS;
          len_err_d  = 1'b0;
          ovf_err_d  = 1'b0;
          line_cnt_d = '0;
          byte_cnt_d = '0;
        end
      end
      WAIT_VS: begin
        if (vs_fall) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (href_s1_q) begin
          if (byte_cnt_q < H_MAX && line_cnt_q < V_MAX) begin
            if (wr_full) begin
              ovf_err_d = 1'b1;
            end else begin
              write_en_d   = 1'b1;
              write_data_d = d_s1_q;
            end
          end
          if (byte_cnt_q != H_SAT) begin
            byte_cnt_d = byte_cnt_q + B_ONE;
          end
        end
        if (href_fall) begin
          if (byte_cnt_q != H_MAX) begin
            len_err_d = 1'b1;
          end
          if (line_cnt_q != L_SAT) begin
            line_cnt_d = line_cnt_q + L_ONE;
          end
          byte_cnt_d = '0;
        end
        // Line check sees a coincident href_fall already counted.
        if (vs_rise) begin
          if (line_cnt_d != V_MAX) begin
            len_err_d = 1'b1;
          end
          frame_end_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge cam_pclk or posedge cam_reset) begin
    if (cam_reset) begin
      state_q       <= IDLE;
      vs_s1_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      href_s1_q     <= 1'b0;
      href_s2_q     <= 1'b0;
      d_s1_q        <= '0;
      byte_cnt_q    <= '0;
      line_cnt_q    <= '0;
      len_err_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      write_en_q    <= 1'b0;
      write_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      vs_s1_q       <= vs_s1_d;
      vs_s2_q       <= vs_s2_d;
      href_s1_q     <= href_s1_d;
      href_s2_q     <= href_s2_d;
      d_s1_q        <= d_s1_d;
      byte_cnt_q    <= byte_cnt_d;
      line_cnt_q    <= line_cnt_d;
      len_err_q     <= len_err_d;
      ovf_err_q     <= ovf_err_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      write_en_q    <= write_en_d;
      write_data_q  <= write_data_d;
    end
  end

  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign write_en    = write_en_q;
  assign write_data  = write_data_q;
  assign busy        = (state_q != IDLE);
  assign line_cnt    = line_cnt_q;
  assign len_err     = len_err_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: scenario frames plus randomized frames checked
// against a per-byte expectation queue built from the frame geometry.
module tb_cam_capture;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          vs;
  logic          href;
  logic [7:0]    d;
  logic          arm;
  logic          full;
  logic          frame_start;
  logic          frame_end;
  logic          write_en;
  logic [7:0]    write_data;
  logic          busy;
  logic [LW-1:0] line_cnt;
  logic          len_err;
  logic          ovf_err;

  cam_capture #(
    .H_BYTES(H),
    .V_LINES(V),
    .LINE_W(LW),
    .VSYNC_POL(1)
  ) dut (
    .cam_pclk(clk),
    .cam_reset(rst),
    .cam_vsync(vs),
    .cam_href(href),
    .cam_d(d),
    .arm(arm),
    .wr_full(full),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .write_en(write_en),
    .write_data(write_data),
    .busy(busy),
    .line_cnt(line_cnt),
    .len_err(len_err),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc_n  = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   fs_cnt = 0;
  int   fe_cnt = 0;
  int   wr_cnt = 0;
  logic full_nxt = 1'b0;
  int   lens[8];

  // Write-stream monitor: every strobe must match the queue head on its
  // due cycle, and every due entry must see a strobe.
  initial forever begin
    @(posedge clk);
    cyc_n++;
    #1;
    if (!rst) begin
      if (write_en === 1'b1) begin
        n_vec++;
        wr_cnt++;
        if (q.size() == 0 || q[0].due != cyc_n) begin
          n_err++;
          $display("FAIL wr_unexpected cyc %0d: got write %02h, required no write",
                   cyc_n, write_data);
        end else begin
          if (write_data !== q[0].data) begin
            n_err++;
            $display("FAIL wr_data cyc %0d: got %02h, required %02h",
                     cyc_n, write_data, q[0].data);
          end
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].due == cyc_n) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_missing cyc %0d: got no write, required %02h",
                 cyc_n, q[0].data);
        void'(q.pop_front());
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (frame_end === 1'b1) fe_cnt++;
    end
  end

  task automatic cyc(input logic v, input logic h, input logic [7:0] dd);
    @(negedge clk);
    full     = full_nxt;
    full_nxt = 1'b0;
    vs       = v;
    href     = h;
    d        = dd;
    arm      = 1'b0;
  endtask

  task automatic frame(input bit cap, input bit arm_pre, input int arm_line,
                       input int nl, input bit rnd, input logic [7:0] base,
                       input int drop, input int rst_line);
    int         bi;
    bit         lerr;
    bit         oerr;
    logic [7:0] dv;
    int         fs0;
    int         fe0;
    bit         exp_busy;
    bi   = 0;
    lerr = 0;
    oerr = 0;
    fs0  = fs_cnt;
    fe0  = fe_cnt;
    cyc(1'b1, 1'b0, 8'h00);
    if (arm_pre) arm = 1'b1;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    repeat (2 + $urandom_range(0, 2)) cyc(1'b0, 1'b0, 8'h00);
    n_vec++;
    if (fs_cnt !== fs0 + (cap ? 1 : 0)) begin
      n_err++;
      $display("FAIL frame_start: got %0d pulses, required %0d",
               fs_cnt - fs0, cap ? 1 : 0);
    end
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < lens[l]; b++) begin
        dv = rnd ? 8'($urandom) : base + 8'(bi);
        cyc(1'b0, 1'b1, dv);
        if (l == rst_line && b == 2) begin
          #2 rst = 1'b1;
          #1;
          n_vec++;
          if (write_en !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: got write_en=%b busy=%b, required 0 0",
                     write_en, busy);
          end
          q.delete();
          full_nxt = 1'b0;
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
          repeat (3) cyc(1'b1, 1'b0, 8'h00);
          n_vec++;
          if (fe_cnt !== fe0 || busy !== 1'b0 || line_cnt !== '0) begin
            n_err++;
            $display("FAIL rst_abort: got fe=%0d busy=%b lines=%0d, required 0 0 0",
                     fe_cnt - fe0, busy, line_cnt);
          end
          return;
        end
        if (arm_line == l && b == 0) arm = 1'b1;
        if (bi == drop) full_nxt = 1'b1;
        if (cap && b < H && l < V) begin
          if (bi == drop) oerr = 1;
          else q.push_back('{cyc_n + 2, dv});
        end
        bi++;
      end
      if (lens[l] != H) lerr = 1;
      repeat (3 + $urandom_range(0, 1)) cyc(1'b0, 1'b0, 8'h00);
      if (cap) begin
        n_vec++;
        if (len_err !== lerr || line_cnt !== LW'(l + 1)) begin
          n_err++;
          $display("FAIL line_%0d: got len_err=%b lines=%0d, required %b %0d",
                   l, len_err, line_cnt, lerr, l + 1);
        end
      end
    end
    if (nl != V) lerr = 1;
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    exp_busy = (arm_line >= 0) && !cap;
    n_vec++;
    if (fe_cnt !== fe0 + (cap ? 1 : 0) || busy !== exp_busy || q.size() != 0) begin
      n_err++;
      $display("FAIL frame_end: got fe=%0d busy=%b pend=%0d, required %0d %b 0",
               fe_cnt - fe0, busy, q.size(), cap ? 1 : 0, exp_busy);
    end
    if (cap) begin
      n_vec++;
      if (line_cnt !== LW'(nl) || len_err !== lerr || ovf_err !== oerr) begin
        n_err++;
        $display("FAIL frame_stat: got lines=%0d len=%b ovf=%b, required %0d %b %b",
                 line_cnt, len_err, ovf_err, nl, lerr, oerr);
      end
    end
  endtask

  task automatic set_lens(input int a, input int b, input int c);
    for (int i = 0; i < 8; i++) lens[i] = H;
    lens[0] = a;
    lens[1] = b;
    lens[2] = c;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    vs   = 1'b0;
    href = 1'b0;
    d    = 8'h00;
    arm  = 1'b0;
    full = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({frame_start, frame_end, write_en, busy, len_err, ovf_err} !== 6'b0 ||
        write_data !== 8'h00 || line_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_vals: got fs=%b fe=%b we=%b busy=%b le=%b oe=%b wd=%02h lc=%0d, required all 0",
               frame_start, frame_end, write_en, busy, len_err, ovf_err,
               write_data, line_cnt);
    end
    rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_basic;
    int w0;
    w0 = wr_cnt;
    set_lens(4, 4, 4);
    frame(1, 1, -1, 3, 0, 8'h10, -1, -1);
    n_vec++;
    if (wr_cnt - w0 !== 12) begin
      n_err++;
      $display("FAIL basic_count: got %0d writes, required 12", wr_cnt - w0);
    end
  endtask

  task automatic test_no_arm;
    set_lens(4, 4, 4);
    frame(0, 0, -1, 3, 1, 8'h00, -1, -1);
  endtask

  task automatic test_mid_arm;
    int w0;
    w0 = wr_cnt;
    set_lens(4, 4, 4);
    frame(0, 0, 1, 3, 0, 8'h40, -1, -1);
    frame(1, 0, -1, 3, 0, 8'h50, -1, -1);
    n_vec++;
    if (wr_cnt - w0 !== 12) begin
      n_err++;
      $display("FAIL mid_arm_count: got %0d writes, required 12", wr_cnt - w0);
    end
  endtask

  task automatic test_bad_len;
    int w0;
    w0 = wr_cnt;
    set_lens(3, 5, 4);
    frame(1, 1, -1, 3, 0, 8'h9D, -1, -1);
    n_vec++;
    if (wr_cnt - w0 !== 11) begin
      n_err++;
      $display("FAIL bad_len_count: got %0d writes, required 11", wr_cnt - w0);
    end
  endtask

  task automatic test_overflow;
    int w0;
    w0 = wr_cnt;
    set_lens(4, 4, 4);
    frame(1, 1, -1, 3, 0, 8'h10, 2, -1);
    n_vec++;
    if (wr_cnt - w0 !== 11) begin
      n_err++;
      $display("FAIL ovf_count: got %0d writes, required 11", wr_cnt - w0);
    end
  endtask

  task automatic test_async_reset;
    int w0;
    set_lens(4, 4, 4);
    frame(1, 1, -1, 3, 0, 8'h60, -1, 1);
    w0 = wr_cnt;
    frame(1, 1, -1, 3, 0, 8'h70, -1, -1);
    n_vec++;
    if (wr_cnt - w0 !== 12) begin
      n_err++;
      $display("FAIL post_rst_count: got %0d writes, required 12", wr_cnt - w0);
    end
  endtask

  task automatic test_random;
    int  nl;
    int  drop;
    int  al;
    bit  cap;
    for (int f = 0; f < 8; f++) begin
      nl = $urandom_range(2, 5);
      for (int i = 0; i < 8; i++)
        lens[i] = ($urandom_range(0, 1) != 0) ? H : $urandom_range(2, 6);
      drop = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : -1;
      cap  = ($urandom_range(0, 3) != 0);
      al   = (cap && $urandom_range(0, 1) != 0) ? $urandom_range(0, nl - 1) : -1;
      frame(cap, cap, al, nl, 1, 8'h00, drop, -1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_no_arm;
    test_mid_arm;
    test_bad_len;
    test_overflow;
    test_async_reset;
    test_random;
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
